// File: rtl/neuron_pkg.sv
// Shared constants and FSM encoding for the 1-input ReLU neuron backward pass.
package neuron_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_LR_SHIFT = 4;
  localparam int unsigned MUL_CYCLES       = DEFAULT_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StMz,
    StMask,
    StMdw,
    StMdx,
    StUpd,
    StOut
  } state_e;

endpackage

// File: rtl/mul_seq_32b1.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b in WIDTH cycles.
// done marks the cycle whose edge completes the product; p is valid from the next cycle on.
module mul_seq_32b1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  // The start edge already consumes bit 0, so WIDTH-1 further edges follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= b[0] ? a : '0;
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
      cnt_q    <= CntW'(WIDTH - 1);
      busy_q   <= (WIDTH > 1);
    end else if (busy_q) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_q <= 1'b0;
    end
  end

  assign done = busy_q && (cnt_q == CntW'(1));
  assign p    = acc_q;

endmodule

// File: rtl/neuron_1input_backprop.sv
// Backward pass of f = relu(w1*x1 + b): weight/bias update and downstream gradient.
// Optional NEURON_BP_ZERO_SKIP_EN skips both gradient products when the ReLU mask is zero.
module neuron_1input_backprop
  import neuron_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned LR_SHIFT = DEFAULT_LR_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] w1,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w1_new,
  output logic [WIDTH-1:0] b_new,
  output logic [WIDTH-1:0] dx1
);

  state_e state_q;
  logic [WIDTH-1:0] x1_q, w1_q, b_q, g_q, gm_q, dw_q;
  logic [WIDTH-1:0] w1_new_q, b_new_q, dx1_q;
  logic             out_valid_q, start_q;

  logic [WIDTH-1:0] mul_a, mul_b, mul_p, z, gm_d, dw_eff, dx_eff;
  logic             mul_done;
  logic signed [WIDTH-1:0] dw_sh, gm_sh;

  always_comb begin
    mul_a = w1_q;
    mul_b = x1_q;
    unique case (state_q)
      StMdw: begin
        mul_a = gm_q;
        mul_b = x1_q;
      end
      StMdx: begin
        mul_a = gm_q;
        mul_b = w1_q;
      end
      default: ;
    endcase
  end

  mul_seq_32b1 #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_q),
    .a    (mul_a),
    .b    (mul_b),
    .done (mul_done),
    .p    (mul_p)
  );

  assign z    = mul_p + b_q;
  assign gm_d = ($signed(z) > 0) ? g_q : '0;

  // Gating on gm keeps stale products out of the result when the products were skipped.
  assign dw_eff = (gm_q == '0) ? '0 : dw_q;
  assign dx_eff = (gm_q == '0) ? '0 : mul_p;
  assign dw_sh  = $signed(dw_eff) >>> LR_SHIFT;
  assign gm_sh  = $signed(gm_q) >>> LR_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x1_q        <= '0;
      w1_q        <= '0;
      b_q         <= '0;
      g_q         <= '0;
      gm_q        <= '0;
      dw_q        <= '0;
      w1_new_q    <= '0;
      b_new_q     <= '0;
      dx1_q       <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x1_q    <= x1;
            w1_q    <= w1;
            b_q     <= b;
            g_q     <= g;
            start_q <= 1'b1;
            state_q <= StMz;
          end
        end
        StMz: begin
          if (mul_done) state_q <= StMask;
        end
        StMask: begin
          gm_q <= gm_d;
`ifdef NEURON_BP_ZERO_SKIP_EN
          if (gm_d == '0) begin
            state_q <= StUpd;
          end else begin
            start_q <= 1'b1;
            state_q <= StMdw;
          end
`else
          start_q <= 1'b1;
          state_q <= StMdw;
`endif
        end
        StMdw: begin
          if (mul_done) begin
            start_q <= 1'b1;
            state_q <= StMdx;
          end
        end
        StMdx: begin
          // First MDX cycle: the dw product is still on p while dx1 is being loaded.
          if (start_q) dw_q <= mul_p;
          if (mul_done) state_q <= StUpd;
        end
        StUpd: begin
          w1_new_q    <= w1_q - dw_sh;
          b_new_q     <= b_q - gm_sh;
          dx1_q       <= dx_eff;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign w1_new    = w1_new_q;
  assign b_new     = b_new_q;
  assign dx1       = dx1_q;

endmodule

// File: tb/tb_neuron_1input_backprop.sv
// Directed self-checking bench for neuron_1input_backprop (WIDTH=32, LR_SHIFT=4).
module tb_neuron_1input_backprop;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x1 = '0, w1 = '0, b = '0, g = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] w1_new, b_new, dx1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_1input_backprop #(
    .WIDTH   (32),
    .LR_SHIFT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x1       (x1),
    .w1       (w1),
    .b        (b),
    .g        (g),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .w1_new   (w1_new),
    .b_new    (b_new),
    .dx1      (dx1)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_for(input bit gm_zero);
`ifdef NEURON_BP_ZERO_SKIP_EN
    return gm_zero ? 34 : 98;
`else
    return 98;
`endif
  endfunction

  task automatic accept(input logic [W-1:0] xv, wv, bv, gv);
    @(negedge clk);
    x1       = xv;
    w1       = wv;
    b        = bv;
    g        = gv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x1       = 32'hdead_beef;
    w1       = 32'h1234_5678;
    b        = 32'h0bad_f00d;
    g        = 32'h7777_0001;
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] xv, wv, bv, gv,
                         input int lat_exp, input logic [W-1:0] ew, eb, ed);
    int lat;
    accept(xv, wv, bv, gv);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, ".latency"}, W'(lat), W'(lat_exp));
    check_eq({tag, ".w1_new"}, w1_new, ew);
    check_eq({tag, ".b_new"}, b_new, eb);
    check_eq({tag, ".dx1"}, dx1, ed);
  endtask

  task automatic finish_txn(input string tag);
    @(negedge clk);
    check_eq({tag, ".in_ready_busy"}, W'(in_ready), W'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".out_valid_drop"}, W'(out_valid), W'(0));
    check_eq({tag, ".in_ready_back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] held;
    #2;
    check_eq("reset.out_valid", W'(out_valid), W'(0));
    check_eq("reset.in_ready", W'(in_ready), W'(1));
    check_eq("reset.w1_new", w1_new, '0);
    check_eq("reset.b_new", b_new, '0);
    check_eq("reset.dx1", dx1, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("basic", 3, 2, 1, 16, 98, 32'hffff_ffff, 0, 32);
    finish_txn("basic");
    run_txn("neg_z", 3, 32'hffff_fffe, 1, 16, lat_for(1'b1), 32'hffff_fffe, 1, 0);
    finish_txn("neg_z");
    run_txn("z_zero", 1, 32'hffff_ffff, 1, 100, lat_for(1'b1), 32'hffff_ffff, 1, 0);
    finish_txn("z_zero");
    run_txn("ashift", 1, 1, 0, 32'hffff_ffff, 98, 2, 1, 32'hffff_ffff);
    finish_txn("ashift");
    run_txn("wrap", 32'h0001_0000, 32'h0001_0000, 5, 1, 98, 32'h0000_f000, 5,
            32'h0001_0000);
    finish_txn("wrap");

    // Backpressure: outputs hold and in_valid pulses are ignored.
    run_txn("hold", 3, 2, 1, 16, 98, 32'hffff_ffff, 0, 32);
    held = w1_new;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      x1       = 7;
      w1       = 9;
      b        = 2;
      g        = 32;
      @(posedge clk);
      #1;
      check_eq("hold.out_valid", W'(out_valid), W'(1));
      check_eq("hold.in_ready", W'(in_ready), W'(0));
      check_eq("hold.w1_new", w1_new, held);
      check_eq("hold.dx1", dx1, 32);
    end
    in_valid = 1'b0;
    finish_txn("hold");
    repeat (5) @(posedge clk);
    #1;
    check_eq("hold.no_stray_txn", W'(in_ready), W'(1));

    // Reset in the middle of a transaction.
    accept(1, 1, 0, 32'hffff_ffff);
    repeat (50) @(posedge clk);
    #1;
    check_eq("rst.busy_before", W'(in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    check_eq("rst.out_valid", W'(out_valid), W'(0));
    check_eq("rst.w1_new", w1_new, '0);
    check_eq("rst.b_new", b_new, '0);
    check_eq("rst.dx1", dx1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst.in_ready", W'(in_ready), W'(1));
    repeat (100) @(posedge clk);
    #1;
    check_eq("rst.no_partial", W'(out_valid), W'(0));

    run_txn("post_rst", 3, 2, 1, 16, 98, 32'hffff_ffff, 0, 32);
    finish_txn("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
